// File: rtl/vedic_pkg.sv
// Shared types and constants for the time-shared vedic multiplier controller:
// FSM state encoding, partial-product index codes and their alignment shifts.
package vedic_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    PP0   = 3'd1,
    PP1   = 3'd2,
    PP2   = 3'd3,
    PP3   = 3'd4,
    DRAIN = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [1:0] PP_LL = 2'd0;
  localparam logic [1:0] PP_LH = 2'd1;
  localparam logic [1:0] PP_HL = 2'd2;
  localparam logic [1:0] PP_HH = 2'd3;

  // Alignment of each partial product, in units of HALF bits
  localparam int SHIFT_LL = 0;
  localparam int SHIFT_LH = 1;
  localparam int SHIFT_HL = 1;
  localparam int SHIFT_HH = 2;

  function automatic int pp_shift(input logic [1:0] idx, input int half);
    case (idx)
      PP_LL:   return SHIFT_LL * half;
      PP_LH:   return SHIFT_LH * half;
      PP_HL:   return SHIFT_HL * half;
      default: return SHIFT_HH * half;
    endcase
  endfunction

endpackage

// File: rtl/cla_nbit.sv
// N-bit accumulator adder; the carry out is dropped because the product always fits.
module cla_nbit #(
  parameter int N = 256
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/vedic_64bit_mul.sv
// Shared HALF x HALF unsigned multiplier core (default 64 x 64), purely combinational.
module vedic_64bit_mul #(
  parameter int N = 64
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_p
);

  assign o_p = {{N{1'b0}}, i_a} * {{N{1'b0}}, i_b};

endmodule

// File: rtl/vedic_pp_sel.sv
// Picks the operand halves for the current partial product and aligns the core
// product into the 2*WIDTH accumulator frame.
module vedic_pp_sel
  import vedic_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic [1:0]         i_pp_idx,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [WIDTH-1:0]   i_prod,
  output logic [WIDTH/2-1:0] o_core_a,
  output logic [WIDTH/2-1:0] o_core_b,
  output logic [2*WIDTH-1:0] o_pp_aligned
);

  localparam int HALF = WIDTH / 2;

  // Index bit 1 selects the high half of a, bit 0 the high half of b
  assign o_core_a     = i_pp_idx[1] ? i_a[WIDTH-1:HALF] : i_a[HALF-1:0];
  assign o_core_b     = i_pp_idx[0] ? i_b[WIDTH-1:HALF] : i_b[HALF-1:0];
  assign o_pp_aligned = {{WIDTH{1'b0}}, i_prod} << pp_shift(i_pp_idx, HALF);

endmodule

// File: rtl/vedic_mul_seq_ctrl.sv
// Iterative WIDTH x WIDTH multiplier: one HALF x HALF core visits LL, LH, HL, HH in turn.
// Build option VEDIC_SEQ_PIPE_EN registers the core product and adds a DRAIN state.
module vedic_mul_seq_ctrl
  import vedic_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] m,
  output logic               busy
);

  localparam int HALF = WIDTH / 2;
`ifdef VEDIC_SEQ_PIPE_EN
  localparam bit PIPE_EN = 1'b1;
`else
  localparam bit PIPE_EN = 1'b0;
`endif

  state_t               r_state, w_state_nxt;
  logic                 r_in_ready, r_out_valid;
  logic [WIDTH-1:0]     r_a, r_b;
  logic [2*WIDTH-1:0]   r_acc, r_m;
  logic [1:0]           w_pp_idx;
  logic                 w_accept, w_acc_en, w_last_add;
  logic [HALF-1:0]      w_core_a, w_core_b;
  logic [WIDTH-1:0]     w_core_p;
  logic [2*WIDTH-1:0]   w_pp_aligned, w_add_in, w_sum;

  assign w_accept = in_valid && r_in_ready;

  vedic_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
    .i_pp_idx     (w_pp_idx),
    .i_a          (r_a),
    .i_b          (r_b),
    .i_prod       (w_core_p),
    .o_core_a     (w_core_a),
    .o_core_b     (w_core_b),
    .o_pp_aligned (w_pp_aligned)
  );

  vedic_64bit_mul #(.N(HALF)) u_core (
    .i_a (w_core_a),
    .i_b (w_core_b),
    .o_p (w_core_p)
  );

  cla_nbit #(.N(2*WIDTH)) u_acc_add (
    .i_a   (r_acc),
    .i_b   (w_add_in),
    .o_sum (w_sum)
  );

  // With the pipe, each add consumes the product computed one state earlier
  always_comb begin
    w_state_nxt = r_state;
    w_pp_idx    = PP_LL;
    w_acc_en    = 1'b0;
    w_last_add  = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = PP0;
      PP0: begin
        w_pp_idx    = PP_LL;
        w_acc_en    = !PIPE_EN;
        w_state_nxt = PP1;
      end
      PP1: begin
        w_pp_idx    = PP_LH;
        w_acc_en    = 1'b1;
        w_state_nxt = PP2;
      end
      PP2: begin
        w_pp_idx    = PP_HL;
        w_acc_en    = 1'b1;
        w_state_nxt = PP3;
      end
      PP3: begin
        w_pp_idx    = PP_HH;
        w_acc_en    = 1'b1;
        w_last_add  = !PIPE_EN;
        w_state_nxt = PIPE_EN ? DRAIN : DONE;
      end
      DRAIN: begin
        w_acc_en    = 1'b1;
        w_last_add  = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: if (r_out_valid && out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef VEDIC_SEQ_PIPE_EN
  logic [2*WIDTH-1:0] r_pp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pp_q <= '0;
    else        r_pp_q <= w_pp_aligned;
  end

  assign w_add_in = r_pp_q;
`else
  assign w_add_in = w_pp_aligned;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_m         <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == IDLE);
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_acc <= '0;
      end else if (w_acc_en) begin
        r_acc <= w_sum;
      end
      if (w_last_add) begin
        r_m         <= w_sum;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign m         = r_m;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_vedic_mul_seq_ctrl.sv
// Directed and randomised bench for vedic_mul_seq_ctrl; honours VEDIC_SEQ_PIPE_EN for latency.
module tb_vedic_mul_seq_ctrl;

  localparam int W = 128;
`ifdef VEDIC_SEQ_PIPE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a, b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] m;
  logic           busy;

  int checks = 0;
  int errors = 0;

  vedic_mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .m         (m),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the block idle; returns at the negedge after the output handshake.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2*W-1:0] ev, input int stall, input string tag);
    int k;
    chk({tag, "_in_ready"}, in_ready, 1);
    a = av; b = bv; in_valid = 1'b1; out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0; a = ~av; b = ~bv;
    k = 1;
    while (!out_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, k, LAT);
    for (int s = 0; s < stall; s++) begin
      chk({tag, "_hold_m"}, m, ev);
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_in_ready"}, in_ready, 0);
      in_valid = 1'b1; a = av ^ W'(s + 1); b = W'(s + 3);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_m"}, m, ev);
    @(negedge clk);
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_m_kept"}, m, ev);
  endtask

  logic [W-1:0]   ones, p64, ra, rb;
  logic [2*W-1:0] ev;

  initial begin
    ones = '1;
    p64  = W'(1) << 64;

    rst_n = 1'b0; in_valid = 1'b1; a = W'(3); b = W'(5); out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_m", m, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_pre_edge", in_ready, 0);
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_not_taken", busy, 0);
    in_valid = 1'b0;

    run_op(W'(3), W'(5), 256'd15, 0, "basic");
    run_op(ones, ones, {{127{1'b1}}, 1'b0, 128'd1}, 0, "all_ones");
    run_op(p64, p64, 256'd1 << 128, 0, "hh_shift");
    run_op(p64, W'(1), 256'd1 << 64, 0, "hl_shift");
    run_op(W'(1), p64, 256'd1 << 64, 0, "lh_shift");
    run_op(W'(0), ones, 256'd0, 0, "a_zero");
    run_op(ones, W'(0), 256'd0, 0, "b_zero");
    run_op(ones, W'(1), {128'd0, ones}, 0, "ones_x1");
    run_op(W'(1000000007), W'(998244353), 256'd998244359987710471, 10, "backpressure");

    a = ones; b = ones; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midop_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midop_rst_valid", out_valid, 0);
    chk("midop_rst_busy", busy, 0);
    chk("midop_rst_m", m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(W'(7), W'(9), 256'd63, 0, "after_rst");

    a = W'(11); b = W'(13); in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 30 && !out_valid; k++) @(negedge clk);
    chk("done_rst_m", m, 256'd143);
    chk("done_rst_valid_pre", out_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk("done_rst_async_drop", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 9))
        0: ra = ones;
        1: rb = ones;
        2: ra = W'($urandom);
        default: ;
      endcase
      ev = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
      run_op(ra, rb, ev, int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
